// File: rtl/kds_loader_if.sv
// rtl/kds_loader_if.sv - word-stream input and KDS-side output bundle for kds_loader
interface kds_loader_if #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int NB_GROUPS     = 12
);
    logic                     start;
    logic [IO_DATA_WIDTH-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [IO_DATA_WIDTH-1:0] v_1;
    logic [IO_DATA_WIDTH-1:0] v_2;
    logic [IO_DATA_WIDTH-1:0] v_3;
    logic [NB_GROUPS-1:0]     LE_select;
    logic                     busy;
    logic                     done;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, v_1, v_2, v_3, LE_select, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, v_1, v_2, v_3, LE_select, busy, done
    );
endinterface

// File: rtl/kds_loader.sv
// rtl/kds_loader.sv - buffers one group of kernel rows, then rewrites that group's KDS lanes
module kds_loader #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int NB_GROUPS     = 12,
    parameter int LOG2_OF_DEPTH = 3
) (
    input  logic         clk,
    input  logic         arst_n_in,
    kds_loader_if.slave  bus
);
    localparam int DEPTH  = 1 << LOG2_OF_DEPTH;
    localparam int NWORDS = 3 * DEPTH;
    localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int GW     = (NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE} state_t;

    state_t                     r_state;
    logic [GW-1:0]              r_group;
    logic [LOG2_OF_DEPTH-1:0]   r_row;
    logic [1:0]                 r_lane;
    logic [WW-1:0]              r_word;
    logic [IO_DATA_WIDTH-1:0]   r_v1, r_v2, r_v3;
    logic [NB_GROUPS-1:0]       r_le;
    logic                       r_busy;
    logic                       r_done;
    logic [IO_DATA_WIDTH-1:0]   r_buf [DEPTH][3];

    logic                       w_ready;
    logic                       w_accept;
    logic                       w_last_word;
    logic                       w_last_row;
    logic                       w_last_group;
    logic [LOG2_OF_DEPTH-1:0]   w_next_row;
    logic [NB_GROUPS-1:0]       w_onehot;
    logic [IO_DATA_WIDTH-1:0]   w_row0_l2;

    assign w_ready      = (r_state == S_FILL);
    assign w_accept     = w_ready && bus.in_valid;
    assign w_last_word  = (r_word == WW'(NWORDS - 1));
    assign w_last_row   = (r_row == LOG2_OF_DEPTH'(DEPTH - 1));
    assign w_last_group = (r_group == GW'(NB_GROUPS - 1));
    assign w_next_row   = r_row + 1'b1;
    assign w_onehot     = NB_GROUPS'(1) << r_group;
    // With a single-row delay line the final word is also row 0 lane 2, so bypass the buffer.
    assign w_row0_l2    = (DEPTH == 1) ? bus.in_data : r_buf[0][2];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_row][r_lane] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state <= S_IDLE;
            r_group <= '0;
            r_row   <= '0;
            r_lane  <= '0;
            r_word  <= '0;
            r_v1    <= '0;
            r_v2    <= '0;
            r_v3    <= '0;
            r_le    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_FILL;
                        r_busy  <= 1'b1;
                        r_group <= '0;
                        r_row   <= '0;
                        r_lane  <= '0;
                        r_word  <= '0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        if (w_last_word) begin
                            // Row 0 goes out on the same edge that takes the last word.
                            r_state <= S_ISSUE;
                            r_word  <= '0;
                            r_row   <= '0;
                            r_lane  <= '0;
                            r_le    <= w_onehot;
                            r_v1    <= r_buf[0][0];
                            r_v2    <= r_buf[0][1];
                            r_v3    <= w_row0_l2;
                        end else begin
                            r_word <= r_word + 1'b1;
                            if (r_lane == 2'd2) begin
                                r_lane <= '0;
                                r_row  <= r_row + 1'b1;
                            end else begin
                                r_lane <= r_lane + 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_last_row) begin
                        r_le  <= '0;
                        r_v1  <= '0;
                        r_v2  <= '0;
                        r_v3  <= '0;
                        r_row <= '0;
                        if (w_last_group) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_group <= r_group + 1'b1;
                            r_state <= S_FILL;
                        end
                    end else begin
                        r_row <= w_next_row;
                        r_v1  <= r_buf[w_next_row][0];
                        r_v2  <= r_buf[w_next_row][1];
                        r_v3  <= r_buf[w_next_row][2];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.v_1       = r_v1;
    assign bus.v_2       = r_v2;
    assign bus.v_3       = r_v3;
    assign bus.LE_select = r_le;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
